// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan driver.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low segment patterns, bit0=a .. bit6=g; entry 15 is listed first.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // True when every nibble from position idx up to the top one is zero.
  // Digit 0 is never considered a leading zero.
  function automatic logic leading_zero(input logic [15:0] data, input logic [1:0] idx);
    logic result;
    result = 1'b0;
    case (idx)
      2'd1:    result = (data[15:4] == 12'h000);
      2'd2:    result = (data[15:8] == 8'h00);
      2'd3:    result = (data[15:12] == 4'h0);
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bundle of scan control, display data and display outputs for the scan driver.
interface seg7_scan_driver_if;

  logic        tick_in;
  logic        enable;
  logic        lzb;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  an_out;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic        frame_done;

  modport master (
    output tick_in, enable, lzb, data_in, dp_in,
    input  an_out, seg_out, dp_out, frame_done
  );

  modport slave (
    input  tick_in, enable, lzb, data_in, dp_in,
    output an_out, seg_out, dp_out, frame_done
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit seven-segment driver: a blanking gap before every digit
// suppresses ghosting, a shadow copy of the data keeps each frame consistent,
// and optional leading-zero blanking darkens unused high digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int BLANK_CYCLES = 16
) (
  input logic            clk_in,
  input logic            reset,
  seg7_scan_driver_if.slave bus
);

  localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES - 1);

  state_t      state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [7:0]  blank_cnt, blank_cnt_nxt;
  logic [15:0] shadow_data, shadow_data_nxt;
  logic [3:0]  shadow_dp, shadow_dp_nxt;
  logic        frame_nxt;

  logic [3:0]  an_reg, an_nxt;
  logic [6:0]  seg_reg, seg_nxt;
  logic        dp_reg, dp_nxt;
  logic        frame_reg;

  logic [3:0]  nibble;
  logic [6:0]  decoded;
  logic        blanked;

  // Next-state logic: enable low wins over everything, ticks only matter in IDLE and ON.
  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    blank_cnt_nxt   = blank_cnt;
    shadow_data_nxt = shadow_data;
    shadow_dp_nxt   = shadow_dp;
    frame_nxt       = 1'b0;
    if (!bus.enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.tick_in) begin
            state_nxt       = ST_BLANK;
            idx_nxt         = 2'd0;
            blank_cnt_nxt   = BLANK_LOAD;
            shadow_data_nxt = bus.data_in;
            shadow_dp_nxt   = bus.dp_in;
          end
        end
        ST_BLANK: begin
          if (blank_cnt == 8'd0) begin
            state_nxt = ST_ON;
          end else begin
            blank_cnt_nxt = blank_cnt - 8'd1;
          end
        end
        ST_ON: begin
          if (bus.tick_in) begin
            state_nxt     = ST_BLANK;
            idx_nxt       = idx + 2'd1;
            blank_cnt_nxt = BLANK_LOAD;
            if (idx == 2'd3) begin
              shadow_data_nxt = bus.data_in;
              shadow_dp_nxt   = bus.dp_in;
              frame_nxt       = 1'b1;
            end
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign nibble = shadow_data_nxt[{idx_nxt, 2'b00} +: 4];

  seg7_hex_decode u_decode (
    .nibble (nibble),
    .seg    (decoded)
  );

  // Output values for the upcoming state so registered outputs change on the same edge.
  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    blanked = bus.lzb && leading_zero(shadow_data_nxt, idx_nxt) && !shadow_dp_nxt[idx_nxt];
    if (state_nxt == ST_ON && !blanked) begin
      an_nxt  = ~(4'b0001 << idx_nxt);
      seg_nxt = decoded;
      dp_nxt  = ~shadow_dp_nxt[idx_nxt];
    end
  end

  // State, counters, shadow copy and registered outputs.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= 2'd0;
      blank_cnt   <= 8'd0;
      shadow_data <= 16'h0000;
      shadow_dp   <= 4'h0;
      an_reg      <= AN_OFF;
      seg_reg     <= SEG_OFF;
      dp_reg      <= 1'b1;
      frame_reg   <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      blank_cnt   <= blank_cnt_nxt;
      shadow_data <= shadow_data_nxt;
      shadow_dp   <= shadow_dp_nxt;
      an_reg      <= an_nxt;
      seg_reg     <= seg_nxt;
      dp_reg      <= dp_nxt;
      frame_reg   <= frame_nxt;
    end
  end

  assign bus.an_out     = an_reg;
  assign bus.seg_out    = seg_reg;
  assign bus.dp_out     = dp_reg;
  assign bus.frame_done = frame_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for the scan driver with a 4-cycle blanking gap.
module tb_seg7_scan_driver;

  logic clk_in = 1'b0;
  logic reset;

  always #5 clk_in = ~clk_in;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.BLANK_CYCLES(4)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic        tick;
    logic        en;
    logic        lz;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dpo;
    logic        fd;
  } vec_t;

  vec_t vecs [30];

  logic [15:0] cur_data;
  logic [3:0]  cur_dp;
  logic        cur_lz;

  function automatic vec_t mk(input logic rst, input logic tick, input logic en,
                              input logic [3:0] an, input logic [6:0] seg,
                              input logic dpo, input logic fd);
    vec_t v;
    v.rst = rst; v.tick = tick; v.en = en; v.lz = 1'b0;
    v.data = 16'h12AF; v.dp = 4'b0100;
    v.an = an; v.seg = seg; v.dpo = dpo; v.fd = fd;
    return v;
  endfunction

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic applyStimulus(input logic rst, input logic tick, input logic en,
                               input logic lz, input logic [15:0] d, input logic [3:0] p);
    reset       = rst;
    bus.tick_in = tick;
    bus.enable  = en;
    bus.lzb     = lz;
    bus.data_in = d;
    bus.dp_in   = p;
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] an, input logic [6:0] seg,
                             input logic dpo, input logic fd);
    total++;
    if ({bus.an_out, bus.seg_out, bus.dp_out, bus.frame_done} !== {an, seg, dpo, fd}) begin
      bad++;
      $display("[TB] FAIL %s: got an=%h seg=%h dp=%b fd=%b, want an=%h seg=%h dp=%b fd=%b",
               name, bus.an_out, bus.seg_out, bus.dp_out, bus.frame_done, an, seg, dpo, fd);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
    checkOutput("reset", 4'hF, 7'h7F, 1'b1, 1'b0);
  endtask

  // One digit slot of the given period: tick, then idle; sample at the last cycle (ON).
  task automatic runSlot(input int period, output logic [3:0] an, output logic [6:0] seg,
                         output logic dpo, output int fd_seen);
    fd_seen = 0;
    for (int s = 0; s < period; s++) begin
      applyStimulus(1'b0, (s == 0), 1'b1, cur_lz, cur_data, cur_dp);
      if (bus.frame_done === 1'b1) fd_seen++;
    end
    an  = bus.an_out;
    seg = bus.seg_out;
    dpo = bus.dp_out;
  endtask

  task automatic slotCheck(input string name, input logic [3:0] an, input logic [6:0] seg,
                           input logic dpo, input int fd);
    logic [3:0] a;
    logic [6:0] g;
    logic       p;
    int         f;
    runSlot(8, a, g, p, f);
    total++;
    if ({a, g, p} !== {an, seg, dpo} || f != fd) begin
      bad++;
      $display("[TB] FAIL %s: got an=%h seg=%h dp=%b fd=%0d, want an=%h seg=%h dp=%b fd=%0d",
               name, a, g, p, f, an, seg, dpo, fd);
    end
  endtask

  logic [3:0] an_exp  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] seg_exp [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};

  initial begin
    int fd_cycles [$];
    reset = 1'b1;
    bus.tick_in = 1'b0; bus.enable = 1'b0; bus.lzb = 1'b0;
    bus.data_in = 16'h0000; bus.dp_in = 4'h0;

    // Cycle-accurate table: 12AF with dp on digit 2, tick in BLANK, enable drop with tick.
    vecs[0]  = mk(1, 0, 0, 4'hF, 7'h7F, 1, 0);
    vecs[1]  = mk(0, 0, 1, 4'hF, 7'h7F, 1, 0);
    vecs[2]  = mk(0, 1, 1, 4'hF, 7'h7F, 1, 0);
    vecs[3]  = mk(0, 0, 1, 4'hF, 7'h7F, 1, 0);
    vecs[4]  = mk(0, 0, 1, 4'hF, 7'h7F, 1, 0);
    vecs[5]  = mk(0, 0, 1, 4'hF, 7'h7F, 1, 0);
    vecs[6]  = mk(0, 0, 1, 4'hE, 7'h0E, 1, 0);
    vecs[7]  = mk(0, 1, 1, 4'hF, 7'h7F, 1, 0);
    vecs[8]  = mk(0, 0, 1, 4'hF, 7'h7F, 1, 0);
    vecs[9]  = mk(0, 0, 1, 4'hF, 7'h7F, 1, 0);
    vecs[10] = mk(0, 0, 1, 4'hF, 7'h7F, 1, 0);
    vecs[11] = mk(0, 0, 1, 4'hD, 7'h08, 1, 0);
    vecs[12] = mk(0, 1, 1, 4'hF, 7'h7F, 1, 0);
    vecs[13] = mk(0, 1, 1, 4'hF, 7'h7F, 1, 0);
    vecs[14] = mk(0, 0, 1, 4'hF, 7'h7F, 1, 0);
    vecs[15] = mk(0, 0, 1, 4'hF, 7'h7F, 1, 0);
    vecs[16] = mk(0, 0, 1, 4'hB, 7'h24, 0, 0);
    vecs[17] = mk(0, 1, 1, 4'hF, 7'h7F, 1, 0);
    vecs[18] = mk(0, 0, 1, 4'hF, 7'h7F, 1, 0);
    vecs[19] = mk(0, 0, 1, 4'hF, 7'h7F, 1, 0);
    vecs[20] = mk(0, 0, 1, 4'hF, 7'h7F, 1, 0);
    vecs[21] = mk(0, 0, 1, 4'h7, 7'h79, 1, 0);
    vecs[22] = mk(0, 1, 1, 4'hF, 7'h7F, 1, 1);
    vecs[23] = mk(0, 0, 1, 4'hF, 7'h7F, 1, 0);
    vecs[24] = mk(0, 0, 1, 4'hF, 7'h7F, 1, 0);
    vecs[25] = mk(0, 0, 1, 4'hF, 7'h7F, 1, 0);
    vecs[26] = mk(0, 0, 1, 4'hE, 7'h0E, 1, 0);
    vecs[27] = mk(0, 1, 0, 4'hF, 7'h7F, 1, 0);
    vecs[28] = mk(0, 0, 1, 4'hF, 7'h7F, 1, 0);
    vecs[29] = mk(0, 0, 1, 4'hF, 7'h7F, 1, 0);

    for (int i = 0; i < 30; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].tick, vecs[i].en, vecs[i].lz, vecs[i].data, vecs[i].dp);
      checkOutput($sformatf("vec%0d", i), vecs[i].an, vecs[i].seg, vecs[i].dpo, vecs[i].fd);
    end

    // Ticks every 20 clocks over two frames plus one more wrap.
    doReset();
    for (int d = 0; d < 9; d++) begin
      for (int s = 0; s < 20; s++) begin
        applyStimulus(1'b0, (s == 0), 1'b1, 1'b0, 16'h12AF, 4'b0100);
        if (bus.frame_done === 1'b1) fd_cycles.push_back(d * 20 + s);
        if (s < 4)
          checkOutput($sformatf("scan d%0d s%0d", d, s), 4'hF, 7'h7F, 1'b1,
                      (s == 0) && (d == 4 || d == 8));
        else if (s == 4 || s == 19)
          checkOutput($sformatf("scan d%0d s%0d", d, s), an_exp[d % 4], seg_exp[d % 4],
                      (d % 4) != 2, 1'b0);
      end
    end
    checkValue("frame_done count", fd_cycles.size(), 2);
    if (fd_cycles.size() == 2)
      checkValue("frame_done spacing", fd_cycles[1] - fd_cycles[0], 80);

    // Leading-zero blanking.
    doReset();
    cur_lz = 1'b1; cur_data = 16'h0005; cur_dp = 4'h0;
    slotCheck("lzb 0005 d0", 4'hE, 7'h12, 1'b1, 0);
    slotCheck("lzb 0005 d1", 4'hF, 7'h7F, 1'b1, 0);
    slotCheck("lzb 0005 d2", 4'hF, 7'h7F, 1'b1, 0);
    slotCheck("lzb 0005 d3", 4'hF, 7'h7F, 1'b1, 0);
    cur_data = 16'h0000;
    slotCheck("lzb 0000 d0", 4'hE, 7'h40, 1'b1, 1);
    slotCheck("lzb 0000 d1", 4'hF, 7'h7F, 1'b1, 0);
    slotCheck("lzb 0000 d2", 4'hF, 7'h7F, 1'b1, 0);
    slotCheck("lzb 0000 d3", 4'hF, 7'h7F, 1'b1, 0);
    cur_dp = 4'b1000;
    slotCheck("lzb dp d0", 4'hE, 7'h40, 1'b1, 1);
    slotCheck("lzb dp d1", 4'hF, 7'h7F, 1'b1, 0);
    slotCheck("lzb dp d2", 4'hF, 7'h7F, 1'b1, 0);
    slotCheck("lzb dp d3", 4'h7, 7'h40, 1'b0, 0);

    // Data change while digit 1 is lit: old nibbles finish the frame.
    doReset();
    cur_lz = 1'b0; cur_data = 16'h1234; cur_dp = 4'h0;
    slotCheck("tear d0", 4'hE, 7'h19, 1'b1, 0);
    slotCheck("tear d1", 4'hD, 7'h30, 1'b1, 0);
    cur_data = 16'h5678;
    slotCheck("tear d2", 4'hB, 7'h24, 1'b1, 0);
    slotCheck("tear d3", 4'h7, 7'h79, 1'b1, 0);
    slotCheck("new d0", 4'hE, 7'h00, 1'b1, 1);
    slotCheck("new d1", 4'hD, 7'h78, 1'b1, 0);

    // Reset while digit 2 is lit, with a coincident tick.
    doReset();
    cur_data = 16'h12AF; cur_dp = 4'b0100;
    slotCheck("pre d0", 4'hE, 7'h0E, 1'b1, 0);
    slotCheck("pre d1", 4'hD, 7'h08, 1'b1, 0);
    slotCheck("pre d2", 4'hB, 7'h24, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h12AF, 4'b0100);
    checkOutput("reset mid-ON", 4'hF, 7'h7F, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h12AF, 4'b0100);
    checkOutput("post reset idle", 4'hF, 7'h7F, 1'b1, 1'b0);
    slotCheck("post reset d0", 4'hE, 7'h0E, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
